fifo_parity_serializer: RTL and testbench

- Downstream consumer of the parity-check FIFO. It pops one WIDTH-bit word at a time when the FIFO is non-empty.
- Each word is sent out on a single serial line as a frame: start bit, data LSB-first, one parity bit (even or odd), stop bit.
- Bit timing comes from a programmable clock divider. This is the transmit stage of the parity-checked link.

---
 rtl/fifo_parity_serializer_pkg.sv | 25 ++
 rtl/fifo_parity_serializer_if.sv | 12 +
 rtl/fifo_parity_serializer_bit_timer.sv | 27 ++
 rtl/fifo_parity_serializer.sv | 98 +++++++++
 tb/tb_fifo_parity_serializer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_parity_serializer_pkg.sv
// Shared types and constants for the parity-framed serial transmitter.
// State encoding, parity selection values and frame-length helpers.
package fifo_ser_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam int DEFAULT_WIDTH = 8;
  // start + data + parity + stop
  localparam int FRAME_BITS = DEFAULT_WIDTH + 3;

  function automatic int frame_bits(input int width);
    return width + 3;
  endfunction

endpackage

// File: rtl/fifo_parity_serializer_if.sv
// FIFO read port seen by the serializer: empty flag, read data and pop strobe.
// Read data is valid the cycle after a pop strobe.
interface fifo_parity_serializer_if #(
  parameter int WIDTH = 8
);
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_rd_en;

  modport master (input fifo_empty, input fifo_dout, output fifo_rd_en);
  modport slave  (output fifo_empty, output fifo_dout, input fifo_rd_en);
endinterface

// File: rtl/fifo_parity_serializer_bit_timer.sv
// Baud counter: counts 0..CLKS_PER_BIT-1, bit_end flags the last cycle of a bit.
// restart holds the count at zero so the next bit starts on a clean boundary.
module ser_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic bit_end
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_end = (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (restart || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/fifo_parity_serializer.sv
// Pops words from a FIFO and sends start, data LSB-first, parity and stop on tx.
// One word per frame; a started frame always completes unless reset aborts it.
module fifo_parity_serializer
  import fifo_ser_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic                     parity_odd,
  fifo_parity_serializer_if.master fifo,
  output logic                     tx,
  output logic                     busy,
  output logic                     frame_done
);
  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] shift_nxt;
  logic [IDXW-1:0]  bit_idx;
  logic             par;
  logic             bit_end;
  logic             restart;

  // Gating with reset_n keeps the pop strobe quiet while reset is held.
  assign fifo.fifo_rd_en = reset_n && (state == IDLE) && en && !fifo.fifo_empty;
  assign busy            = (state != IDLE) || fifo.fifo_rd_en;
  assign frame_done      = (state == STOP) && bit_end;
  assign restart         = (state == IDLE) || (state == FETCH);
  assign shift_nxt       = shift >> 1;

  ser_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (restart),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      tx      <= 1'b1;
      shift   <= '0;
      bit_idx <= '0;
      par     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo.fifo_rd_en) state <= FETCH;
        end
        FETCH: begin
          // parity_odd is captured here so later changes cannot touch this frame
          shift   <= fifo.fifo_dout;
          par     <= (^fifo.fifo_dout) ^ parity_odd;
          tx      <= 1'b0;
          bit_idx <= '0;
          state   <= START;
        end
        START: begin
          if (bit_end) begin
            tx      <= shift[0];
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == LAST_IDX) begin
              tx    <= par;
              state <= PARITY;
            end else begin
              shift   <= shift_nxt;
              tx      <= shift_nxt[0];
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          if (bit_end) state <= IDLE;
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_parity_serializer.sv
// Drives a queue-backed FIFO model and decodes tx independently, comparing
// each frame, its timing and frame_done against a scoreboard of pushed words.
module tb_fifo_parity_serializer;
  import fifo_ser_pkg::*;

  localparam int WIDTH = 8;
  localparam int CPB   = 4;
  localparam int NB    = frame_bits(WIDTH);
  localparam int FLEN  = NB * CPB;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic en = 1'b0;
  logic parity_odd = PARITY_EVEN;
  logic tx, busy, frame_done;

  fifo_parity_serializer_if #(.WIDTH(WIDTH)) fif ();

  fifo_parity_serializer #(.WIDTH(WIDTH), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .parity_odd (parity_odd),
    .fifo       (fif),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] w;
    logic             p;
  } exp_t;

  logic [WIDTH-1:0] fq[$];
  exp_t             exp_q[$];

  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc = 0;
  int rd_cyc = -100;
  int rd_cnt = 0;
  int frames = 0;
  int st = 0;
  int last_end = -1;
  int base;
  bit in_frame = 1'b0;
  bit gap_chk = 1'b0;
  bit pop_pend = 1'b0;
  logic [NB-1:0] bits = '0;
  logic [NB-1:0] last_bits = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w);
    exp_t e;
    e.w = w;
    e.p = (^w) ^ parity_odd;
    fq.push_back(w);
    exp_q.push_back(e);
    fif.fifo_empty = 1'b0;
  endtask

  task automatic monitor();
    int off;
    bit exp_done;
    exp_t e;
    if (!in_frame && tx === 1'b0) begin
      in_frame = 1'b1;
      st = cyc;
      check("start_latency", cyc - rd_cyc, 2);
      if (gap_chk && last_end >= 0) check("frame_gap", cyc - last_end, 3);
    end
    if (in_frame) begin
      off = cyc - st;
      if (off % CPB == CPB / 2) bits[off / CPB] = tx;
      exp_done = (off == FLEN - 1);
      if (frame_done || exp_done) check("frame_done", frame_done, exp_done);
      if (exp_done) begin
        in_frame = 1'b0;
        last_end = cyc;
        frames++;
        last_bits = bits;
        check("busy_in_frame", busy, 1);
        check("start_bit", bits[0], 0);
        check("stop_bit", bits[NB-1], 1);
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 0, 1);
        end else begin
          e = exp_q.pop_front();
          check("data_bits", bits[WIDTH:1], e.w);
          check("parity_bit", bits[NB-2], e.p);
        end
      end
    end else if (frame_done) begin
      check("frame_done_idle", frame_done, 0);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    monitor();
    if (fif.fifo_rd_en) begin
      rd_cnt++;
      rd_cyc = cyc;
      pop_pend = 1'b1;
      if (!en) check("pop_while_disabled", 1, 0);
    end
    @(posedge clk);
    #1;
    if (pop_pend) begin
      fif.fifo_dout = fq.pop_front();
      fif.fifo_empty = (fq.size() == 0);
      pop_pend = 1'b0;
    end
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames < target && n < budget) begin
      step();
      n++;
    end
    check("frames_reached", frames, target);
  endtask

  task automatic wait_data(input int budget);
    int n = 0;
    while (!(in_frame && (cyc - st) >= 2 * CPB) && n < budget) begin
      step();
      n++;
    end
    check("reached_data", in_frame, 1);
  endtask

  initial begin
    fif.fifo_empty = 1'b1;
    fif.fifo_dout  = '0;

    // Reset holds everything quiet even with a non-empty FIFO and en high
    en = 1'b1;
    fif.fifo_empty = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_rd_en", fif.fifo_rd_en, 0);
    check("rst_frame_done", frame_done, 0);
    fif.fifo_empty = 1'b1;
    reset_n = 1'b1;

    repeat (50) step();
    check("empty_no_pop", rd_cnt, 0);
    check("empty_tx", tx, 1);
    check("empty_busy", busy, 0);

    // Single frames with both parity senses
    parity_odd = PARITY_EVEN;
    push_word(8'hA5);
    wait_frames(frames + 1, FLEN + 20);
    check("a5_data", last_bits[WIDTH:1], 8'hA5);
    check("a5_even_par", last_bits[NB-2], 0);

    parity_odd = PARITY_ODD;
    push_word(8'hA5);
    wait_data(20);
    parity_odd = PARITY_EVEN;
    wait_frames(frames + 1, FLEN + 20);
    check("a5_odd_par", last_bits[NB-2], 1);

    push_word(8'h07);
    wait_frames(frames + 1, FLEN + 20);
    check("07_even_par", last_bits[NB-2], 1);

    // Back-to-back frames with the minimum idle gap
    base = rd_cnt;
    last_end = -1;
    gap_chk = 1'b1;
    push_word(8'h01);
    push_word(8'hFF);
    push_word(8'h80);
    wait_frames(frames + 3, 3 * FLEN + 40);
    gap_chk = 1'b0;
    check("three_pops", rd_cnt - base, 3);

    // en dropped mid-frame: the frame finishes, the next pop waits for en
    base = rd_cnt;
    push_word(8'h5A);
    push_word(8'h96);
    wait_data(20);
    en = 1'b0;
    wait_frames(frames + 1, FLEN + 20);
    repeat (20) step();
    check("en_low_pops", rd_cnt - base, 1);
    check("en_low_busy", busy, 0);
    en = 1'b1;
    wait_frames(frames + 1, FLEN + 20);
    check("en_high_pops", rd_cnt - base, 2);

    // Reset during DATA aborts the frame; the next word is framed cleanly
    base = rd_cnt;
    push_word(8'h3C);
    push_word(8'hC3);
    wait_data(20);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    in_frame = 1'b0;
    exp_q.delete(0);
    step();
    step();
    reset_n = 1'b1;
    wait_frames(frames + 1, FLEN + 20);
    check("post_rst_pops", rd_cnt - base, 2);
    check("post_rst_data", last_bits[WIDTH:1], 8'hC3);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
